// File: rtl/min_pkg.sv
// Shared types and constants for the streaming minimum finder.
// Holds the controller state encoding and the default element/frame sizes.
package min_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MAX_LEN = 16;

    // Reported as the minimum of an empty frame.
    localparam logic [DEF_DATA_W-1:0] EMPTY_MIN = '1;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ACC,
        DONE
    } min_state_t;

endpackage

// File: rtl/min2_unit.sv
// Two-input unsigned min comparator, shared by the stream controller.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module min2_unit #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] min,
    output logic              a_lt_b
);

    // Strict compare so ties resolve to b, the value already held.
    assign a_lt_b = (a < b);
    assign min    = a_lt_b ? a : b;

endmodule

// File: rtl/min_stream_ctrl.sv
// Frame minimum finder: streams len values through one shared comparator.
// Latency: result valid len+1 cycles after start when the input never stalls.
// Backpressure: in_ready only while collecting; result held until out_ready.
module min_stream_ctrl
    import min_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [LEN_W-1:0]  out_idx,
    output logic              out_empty,
    output logic              busy
);

    min_state_t        state_q, state_d;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] min_q;
    logic [LEN_W-1:0]  idx_q;
    logic              empty_q;

    logic [LEN_W-1:0]  len_clamp;
    logic              last_elem;
    logic [DATA_W-1:0] cmp_min;
    logic              cmp_lt;

    assign len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign last_elem = (rem_q == LEN_W'(1));

    min2_unit #(
        .DATA_W (DATA_W)
    ) u_min2 (
        .a      (in_data),
        .b      (min_q),
        .min    (cmp_min),
        .a_lt_b (cmp_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // in_ready is asserted throughout FIRST/ACC, so in_valid alone marks an accept there.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_clamp == '0) ? DONE : FIRST;
                end
            end
            FIRST, ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = last_elem ? DONE : ACC;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            cnt_q   <= '0;
            min_q   <= '0;
            idx_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q <= len_clamp;
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (len_clamp == '0) begin
                            min_q   <= {DATA_W{EMPTY_MIN[0]}};
                            empty_q <= 1'b1;
                        end else begin
                            empty_q <= 1'b0;
                        end
                    end
                end
                FIRST: begin
                    if (in_valid) begin
                        min_q <= in_data;
                        idx_q <= '0;
                        cnt_q <= LEN_W'(1);
                        rem_q <= rem_q - LEN_W'(1);
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        min_q <= cmp_min;
                        if (cmp_lt) begin
                            idx_q <= cnt_q;
                        end
                        cnt_q <= cnt_q + LEN_W'(1);
                        rem_q <= rem_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_min   = min_q;
    assign out_idx   = idx_q;
    assign out_empty = empty_q;

endmodule
